flopr_pipe: RTL and testbench

FLOPR_PIPE -- requirements
Module: flopr_pipe

---
 rtl/flopr_pipe.sv | 54 +++++
 tb/tb_flopr_pipe.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/flopr_pipe.sv
// flopr_pipe: elastic register pipeline with valid/ready handshake.
// Valid stages advance into empty or draining successors, so bubbles collapse.
module flopr_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH+1);
    logic [DEPTH-1:0] v, move;
    logic [WIDTH-1:0] d [DEPTH];
    logic push, pop;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign pop       = out_valid & out_ready;
    assign in_ready  = ~clr & (~v[0] | move[0]);
    assign push      = in_valid & in_ready;
    // Advance permission ripples backwards from the output stage.
    always_comb begin
        move[DEPTH-1] = pop;
        for (int i = DEPTH-2; i >= 0; i--)
            move[i] = v[i] & (~v[i+1] | move[i+1]);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v     <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++)
                d[i] <= '0;
        end else if (clr) begin
            v     <= '0;
            count <= '0;
        end else begin
            v[0] <= push | (v[0] & ~move[0]);
            if (push)
                d[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                v[i] <= move[i-1] | (v[i] & ~move[i]);
                if (move[i-1])
                    d[i] <= d[i-1];
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_flopr_pipe.sv
// tb_flopr_pipe: checks flopr_pipe against a queue-of-items model where each
// item moves one stage per edge, limited only by the item ahead of it.
module tb_flopr_pipe;
    localparam int W = 8;
    localparam int D = 4;

    logic clk = 0, rst = 0, clr = 0, in_valid = 0, out_ready = 0;
    logic in_ready, out_valid;
    logic [W-1:0] in_data = '0, out_data;
    logic [$clog2(D+1)-1:0] count;
    int n_chk = 0, n_fail = 0;

    flopr_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
    );

    always #5 clk = ~clk;

    logic [W-1:0] mq_d[$];
    int           mq_p[$];

    function automatic bit m_valid();
        return mq_p.size() > 0 && mq_p[0] == D-1;
    endfunction

    // Stage 0 is free after this edge if the newest item leaves it (or there is none).
    function automatic bit m_ready();
        int lim, np, j0;
        bit pop;
        if (clr) return 1'b0;
        if (mq_p.size() == 0) return 1'b1;
        pop = m_valid() && out_ready;
        j0 = pop ? 1 : 0;
        if (j0 >= mq_p.size()) return 1'b1;
        lim = D;
        np = 0;
        for (int j = j0; j < mq_p.size(); j++) begin
            np = (mq_p[j] + 1 < lim - 1) ? mq_p[j] + 1 : lim - 1;
            lim = np;
        end
        return np > 0;
    endfunction

    bit m_rdy, m_pop;
    int m_lim;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq_d.delete();
            mq_p.delete();
        end else begin
            m_rdy = m_ready();
            m_pop = m_valid() && out_ready;
            if (clr) begin
                mq_d.delete();
                mq_p.delete();
            end else begin
                if (m_pop) begin
                    void'(mq_d.pop_front());
                    void'(mq_p.pop_front());
                end
                m_lim = D;
                foreach (mq_p[j]) begin
                    mq_p[j] = (mq_p[j] + 1 < m_lim - 1) ? mq_p[j] + 1 : m_lim - 1;
                    m_lim = mq_p[j];
                end
                if (in_valid && m_rdy) begin
                    mq_d.push_back(in_data);
                    mq_p.push_back(0);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("out_valid", 32'(out_valid), 32'(m_valid()));
            chk("count", 32'(count), 32'(mq_p.size()));
            chk("in_ready", 32'(in_ready), 32'(m_ready()));
            if (m_valid())
                chk("out_data", 32'(out_data), 32'(mq_d[0]));
        end
    end

    task automatic drive(input bit iv, input logic [W-1:0] id, input bit ordy, input bit c);
        in_valid = iv;
        in_data = id;
        out_ready = ordy;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1 rst = 0;

        // latency: one item reaches the output DEPTH-1 edges after its push
        drive(1, 8'hA5, 1, 0);
        chk("lat_count", 32'(count), 1);
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        chk("lat_early", 32'(out_valid), 0);
        drive(0, 0, 1, 0);
        chk("lat_valid", 32'(out_valid), 1);
        chk("lat_data", 32'(out_data), 32'hA5);
        chk("lat_count1", 32'(count), 1);
        drive(0, 0, 1, 0);
        chk("lat_count0", 32'(count), 0);

        // streaming
        for (int i = 0; i < 16; i++) begin
            drive(1, W'(i), 1, 0);
            if (i >= 3) begin
                chk("stream_data", 32'(out_data), 32'(i - 3));
                chk("stream_ready", 32'(in_ready), 1);
            end
        end
        repeat (4) drive(0, 0, 1, 0);
        chk("stream_empty", 32'(count), 0);

        // backpressure
        for (int k = 0; k < 6; k++) begin
            drive(1, W'(k), 0, 0);
            if (k >= 3) chk("bp_data", 32'(out_data), 0);
        end
        chk("bp_count", 32'(count), 4);
        chk("bp_in_ready", 32'(in_ready), 0);
        out_ready = 1;
        #1 chk("bp_ready_comb", 32'(in_ready), 1);
        drive(1, 4, 1, 0);
        chk("bp_count_a", 32'(count), 4);
        chk("bp_data_a", 32'(out_data), 1);
        drive(1, 5, 1, 0);
        chk("bp_count_b", 32'(count), 4);
        chk("bp_data_b", 32'(out_data), 2);
        for (int k = 3; k < 6; k++) begin
            drive(0, 0, 1, 0);
            chk("bp_drain", 32'(out_data), 32'(k));
        end
        drive(0, 0, 1, 0);
        chk("bp_empty", 32'(count), 0);

        // bubble collapse
        drive(1, 1, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(1, 2, 0, 0);
        repeat (3) drive(0, 0, 0, 0);
        chk("bub_count", 32'(count), 2);
        chk("bub_ready", 32'(in_ready), 1);
        chk("bub_data", 32'(out_data), 1);
        drive(0, 0, 1, 0);
        chk("bub_next", 32'(out_data), 2);
        chk("bub_count1", 32'(count), 1);
        drive(0, 0, 1, 0);
        chk("bub_empty", 32'(count), 0);

        // synchronous flush
        for (int k = 0; k < 4; k++) drive(1, W'(10 + k), 0, 0);
        chk("clr_full", 32'(count), 4);
        in_valid = 1;
        in_data = 8'h99;
        out_ready = 1;
        clr = 1;
        #1 chk("clr_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        clr = 0;
        in_valid = 0;
        chk("clr_count", 32'(count), 0);
        chk("clr_valid", 32'(out_valid), 0);
        repeat (4) drive(0, 0, 1, 0);
        chk("clr_nothing", 32'(count), 0);

        // asynchronous reset mid-stream
        for (int i = 0; i < 6; i++) drive(1, W'(20 + i), 1, 0);
        #1 rst = 1;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_data", 32'(out_data), 0);
        chk("arst_count", 32'(count), 0);
        chk("arst_ready", 32'(in_ready), 1);
        in_valid = 0;
        #1 rst = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, W'(30 + i), 1, 0);
            if (i == 3) begin
                chk("arst_restart", 32'(out_data), 30);
                chk("arst_cnt4", 32'(count), 4);
            end
        end
        repeat (4) drive(0, 0, 1, 0);
        chk("arst_empty", 32'(count), 0);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
